// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller.
// Holds the register map, the CTRL/STATUS bit positions and the receiver
// state encoding so the register file, the serial core and any bench agree.
package uart_pkg;

  // Register addresses on the 4-bit bus
  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_DATA   = 4'h8;
  localparam logic [3:0] ADDR_BAUD   = 4'hC;

  // CTRL bit positions (FLUSH is write-only and never stored)
  localparam int CTRL_EN      = 0;
  localparam int CTRL_RXIE    = 1;
  localparam int CTRL_ERRIE   = 2;
  localparam int CTRL_PAR_EN  = 3;
  localparam int CTRL_PAR_ODD = 4;
  localparam int CTRL_FLUSH   = 7;

  // STATUS bit positions; bits [7:5] read as zero
  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVR       = 2;
  localparam int STAT_PERR      = 3;
  localparam int STAT_FERR      = 4;

  // Receiver FSM states
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// Serial receive engine: 2-flop synchroniser, start-bit detection with
// glitch rejection, LSB-first data sampling, optional parity and stop check.
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   en              - receiver enable; low forces the FSM back to idle
//   par_en, par_odd - parity enable and odd/even select
//   baud            - clocks per bit, latched at start-bit detection
//   rx_serial       - asynchronous serial line, idle high
//   idle            - FSM is in the idle state
//   frame_valid     - one-cycle pulse, the cycle after a good stop sample
//   frame_data      - received data bits, valid while frame_valid is high
//   perr_set        - pulse on parity mismatch
//   ferr_set        - pulse on a low stop bit
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              par_en,
  input  logic              par_odd,
  input  logic [7:0]        baud,
  input  logic              rx_serial,
  output logic              idle,
  output logic              frame_valid,
  output logic [DATA_W-1:0] frame_data,
  output logic              perr_set,
  output logic              ferr_set
);

  rx_state_e         state_q, state_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              prev_q, prev_d;
  logic [7:0]        clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        baud_lat_q, baud_lat_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              bad_q, bad_d;
  logic              valid_q, valid_d;

  logic line;
  logic fall;
  logic half_tick;
  logic bit_tick;
  logic parity_err;

  // Sampling strobes derived from the synchronised line and the bit timer.
  // The start bit is checked half a bit in; every later sample is one full
  // bit after the previous one, which keeps all samples near mid-bit.
  always_comb begin
    line       = sync2_q;
    fall       = prev_q & ~sync2_q;
    half_tick  = (clk_cnt_q == {1'b0, baud_lat_q[7:1]});
    bit_tick   = (clk_cnt_q == (baud_lat_q - 8'd1));
    parity_err = (^shift_q) ^ line ^ par_odd;
  end

  // State register plus synchroniser, counters and shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RX_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      baud_lat_q <= '0;
      shift_q    <= '0;
      bad_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_lat_q <= baud_lat_d;
      shift_q    <= shift_d;
      bad_q      <= bad_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state logic and datapath updates
  always_comb begin
    sync1_d    = rx_serial;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q + 8'd1;
    bit_cnt_d  = bit_cnt_q;
    baud_lat_d = baud_lat_q;
    shift_d    = shift_q;
    bad_d      = bad_q;

    if (!en) begin
      // Disabling drops any partial frame immediately
      state_d   = RX_IDLE;
      clk_cnt_d = '0;
    end else begin
      unique case (state_q)
        RX_IDLE: begin
          clk_cnt_d = '0;
          if (fall) begin
            // BAUD is latched here so a write mid-frame only affects the next frame
            state_d    = RX_START;
            baud_lat_d = baud;
            bit_cnt_d  = '0;
            shift_d    = '0;
            bad_d      = 1'b0;
          end
        end
        RX_START: begin
          if (half_tick) begin
            clk_cnt_d = '0;
            state_d   = line ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (bit_tick) begin
            clk_cnt_d          = '0;
            shift_d[bit_cnt_q] = line;
            if (bit_cnt_q == 3'(DATA_W - 1)) begin
              bit_cnt_d = '0;
              state_d   = par_en ? RX_PARITY : RX_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        RX_PARITY: begin
          if (bit_tick) begin
            clk_cnt_d = '0;
            bad_d     = parity_err;
            state_d   = RX_STOP;
          end
        end
        RX_STOP: begin
          if (bit_tick) begin
            clk_cnt_d = '0;
            state_d   = RX_IDLE;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  // Outputs: error pulses at the sample point, frame strobe one cycle later
  always_comb begin
    idle        = (state_q == RX_IDLE);
    perr_set    = en && (state_q == RX_PARITY) && bit_tick && parity_err;
    ferr_set    = en && (state_q == RX_STOP) && bit_tick && !line;
    valid_d     = en && (state_q == RX_STOP) && bit_tick && line && !bad_q;
    frame_valid = valid_q;
    frame_data  = shift_q;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: register file, receive FIFO and interrupt logic
// wrapped around the serial receive core.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   read/write - single-cycle bus strobes
//   addr       - 0x0 CTRL, 0x4 STATUS, 0x8 DATA, 0xC BAUD
//   data_in    - bus write data
//   rx_serial  - asynchronous serial input, idle high
//   interrupt  - level interrupt request
//   ready      - receiver enabled and idle
//   data_out   - combinational read data for addr (0 when unmapped)
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       read,
  input  logic       write,
  input  logic [3:0] addr,
  input  logic [7:0] data_in,
  input  logic       rx_serial,
  output logic       interrupt,
  output logic       ready,
  output logic [7:0] data_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]       ctrl_q, ctrl_d;
  logic [7:0]       baud_q, baud_d;
  logic             ovr_q, ovr_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic              core_idle;
  logic              core_valid;
  logic [DATA_W-1:0] core_data;
  logic              core_perr;
  logic              core_ferr;

  logic       wr_ctrl, wr_baud, rd_status, rd_data;
  logic       flush, empty, full, pop, mem_we, ovr_set;
  logic [7:0] head_ext;

  uart_rx_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .en          (ctrl_q[CTRL_EN]),
    .par_en      (ctrl_q[CTRL_PAR_EN]),
    .par_odd     (ctrl_q[CTRL_PAR_ODD]),
    .baud        (baud_q),
    .rx_serial   (rx_serial),
    .idle        (core_idle),
    .frame_valid (core_valid),
    .frame_data  (core_data),
    .perr_set    (core_perr),
    .ferr_set    (core_ferr)
  );

  // Register, flag and FIFO pointer state
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= '0;
      baud_q   <= 8'(CLKS_PER_BIT);
      ovr_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      baud_q   <= baud_d;
      ovr_q    <= ovr_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage needs no reset; occupancy decides what is valid
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= core_data;
    end
  end

  // Bus decode, FIFO bookkeeping and sticky error flags
  always_comb begin
    wr_ctrl   = write && (addr == ADDR_CTRL);
    wr_baud   = write && (addr == ADDR_BAUD);
    rd_status = read && (addr == ADDR_STATUS);
    rd_data   = read && (addr == ADDR_DATA);
    flush     = wr_ctrl && data_in[CTRL_FLUSH];
    empty     = (count_q == '0);
    full      = (count_q == CNT_W'(FIFO_DEPTH));
    pop       = rd_data && !empty;

    ctrl_d = wr_ctrl ? data_in[4:0] : ctrl_q;
    baud_d = wr_baud ? data_in : baud_q;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_we   = 1'b0;
    ovr_set  = 1'b0;

    if (flush) begin
      // Flush wins over a same-cycle push or pop
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // When full, a coincident pop frees the slot the push writes into
      mem_we  = core_valid && (!full || pop);
      ovr_set = core_valid && full && !pop;
      if (mem_we) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({mem_we, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    // A new error in the same cycle as a STATUS read stays set
    ovr_d  = ovr_set   || (ovr_q  && !rd_status);
    perr_d = core_perr || (perr_q && !rd_status);
    ferr_d = core_ferr || (ferr_q && !rd_status);
  end

  // Read mux and interrupt/ready outputs
  always_comb begin
    head_ext = '0;
    if (!empty) begin
      head_ext[DATA_W-1:0] = mem_q[rd_ptr_q];
    end

    unique case (addr)
      ADDR_CTRL:   data_out = {3'b000, ctrl_q};
      ADDR_STATUS: data_out = {3'b000, ferr_q, perr_q, ovr_q, full, !empty};
      ADDR_DATA:   data_out = head_ext;
      ADDR_BAUD:   data_out = baud_q;
      default:     data_out = 8'h00;
    endcase

    interrupt = (ctrl_q[CTRL_RXIE] && !empty) ||
                (ctrl_q[CTRL_ERRIE] && (ovr_q || perr_q || ferr_q));
    ready     = ctrl_q[CTRL_EN] && core_idle;
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with default parameters (8 data bits,
// 8-entry FIFO, BAUD reset value 87). Serial frames are driven at 16 clocks
// per bit; inputs change on the falling clock edge and outputs are checked
// there too, away from the rising edge where the DUT updates.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int BIT_CLKS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       read;
  logic       write;
  logic [3:0] addr;
  logic [7:0] data_in;
  logic       rx_serial;
  logic       interrupt;
  logic       ready;
  logic [7:0] data_out;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] rd_val;
  logic [7:0] act_val;

  uart_rx_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .read      (read),
    .write     (write),
    .addr      (addr),
    .data_in   (data_in),
    .rx_serial (rx_serial),
    .interrupt (interrupt),
    .ready     (ready),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its hand-derived expectation
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=0x%02h expected=0x%02h", tag, observed, expected);
    end
  endtask

  // Single-cycle register write
  task automatic busWrite(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    write   = 1'b1;
    addr    = a;
    data_in = d;
    @(negedge clk);
    write   = 1'b0;
  endtask

  // Single-cycle register read; data_out is captured while the strobe is high
  task automatic busRead(input logic [3:0] a, output logic [7:0] v);
    @(negedge clk);
    read = 1'b1;
    addr = a;
    #1 v = data_out;
    @(negedge clk);
    read = 1'b0;
  endtask

  // Drive one serial frame (start, 8 data bits LSB-first, optional parity,
  // stop). Optionally performs one bus action at clock act_clk of the frame:
  // act_kind 1 = DATA read (value returned in act_out), 2 = write CTRL=0.
  task automatic applyStimulus(input logic [7:0] data, input bit use_par,
                               input bit par_bit, input bit stop_bit,
                               input int act_clk, input int act_kind,
                               output logic [7:0] act_out);
    logic [10:0] seq;
    int nbits;
    seq      = {stop_bit, (use_par ? par_bit : stop_bit), data, 1'b0};
    nbits    = use_par ? 11 : 10;
    act_out  = 8'h00;
    for (int b = 0; b < nbits; b++) begin
      for (int k = 0; k < BIT_CLKS; k++) begin
        @(negedge clk);
        rx_serial = seq[b];
        read      = 1'b0;
        write     = 1'b0;
        if ((b * BIT_CLKS + k) == act_clk) begin
          if (act_kind == 1) begin
            read = 1'b1;
            addr = ADDR_DATA;
            #1 act_out = data_out;
          end else if (act_kind == 2) begin
            write   = 1'b1;
            addr    = ADDR_CTRL;
            data_in = 8'h00;
          end
        end
      end
    end
    rx_serial = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    read      = 1'b0;
    write     = 1'b0;
    addr      = ADDR_BAUD;
    data_in   = 8'h00;
    rx_serial = 1'b1;

    // Reset values, checked while reset is held and just after release
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_irq", {7'd0, interrupt}, 8'h00);
    checkOutput("rst_ready", {7'd0, ready}, 8'h00);
    checkOutput("rst_baud", data_out, 8'd87);
    rst = 1'b0;
    busRead(ADDR_CTRL, rd_val);
    checkOutput("rst_ctrl", rd_val, 8'h00);
    busRead(ADDR_STATUS, rd_val);
    checkOutput("rst_status", rd_val, 8'h00);
    busRead(ADDR_DATA, rd_val);
    checkOutput("empty_data_read", rd_val, 8'h00);
    busRead(ADDR_BAUD, rd_val);
    checkOutput("rst_baud_read", rd_val, 8'd87);

    // Basic 8N1 reception of 0xA5 with RX interrupt enabled
    busWrite(ADDR_BAUD, 8'd16);
    busWrite(ADDR_CTRL, 8'h03);
    busRead(ADDR_CTRL, rd_val);
    checkOutput("ctrl_rw", rd_val, 8'h03);
    checkOutput("ready_en", {7'd0, ready}, 8'h01);
    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1, -1, 0, act_val);
    checkOutput("rx_irq", {7'd0, interrupt}, 8'h01);
    busRead(ADDR_STATUS, rd_val);
    checkOutput("a5_not_empty", rd_val, 8'h01);
    busRead(ADDR_DATA, rd_val);
    checkOutput("a5_data", rd_val, 8'hA5);
    busRead(ADDR_STATUS, rd_val);
    checkOutput("a5_empty_after", rd_val, 8'h00);
    checkOutput("rx_irq_clear", {7'd0, interrupt}, 8'h00);

    // Even parity: 0x03 has two ones so a parity bit of 1 is wrong
    busWrite(ADDR_CTRL, 8'h0D);
    applyStimulus(8'h03, 1'b1, 1'b1, 1'b1, -1, 0, act_val);
    checkOutput("perr_irq", {7'd0, interrupt}, 8'h01);
    busRead(ADDR_STATUS, rd_val);
    checkOutput("perr_status", rd_val, 8'h08);
    checkOutput("perr_irq_clear", {7'd0, interrupt}, 8'h00);
    busRead(ADDR_STATUS, rd_val);
    checkOutput("perr_cleared", rd_val, 8'h00);
    applyStimulus(8'h03, 1'b1, 1'b0, 1'b1, -1, 0, act_val);
    busRead(ADDR_DATA, rd_val);
    checkOutput("par_good_data", rd_val, 8'h03);

    // Overflow: nine frames into an eight-entry FIFO
    busWrite(ADDR_CTRL, 8'h01);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(8'(i), 1'b0, 1'b0, 1'b1, -1, 0, act_val);
    end
    busRead(ADDR_STATUS, rd_val);
    checkOutput("ovr_status", rd_val, 8'h07);
    for (int i = 0; i < 8; i++) begin
      busRead(ADDR_DATA, rd_val);
      checkOutput("ovr_fifo_order", rd_val, 8'(i));
    end
    busRead(ADDR_STATUS, rd_val);
    checkOutput("ovr_drained", rd_val, 8'h00);

    // Full FIFO with a pop coincident with the ninth push. The push happens
    // in the clock starting at negedge 156 of the frame: 2 synchroniser
    // flops, 1 detect cycle, 8 clocks to mid-start, 9 bits of 16 clocks,
    // then the one-cycle push delay.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'h10 + 8'(i), 1'b0, 1'b0, 1'b1, -1, 0, act_val);
    end
    applyStimulus(8'h18, 1'b0, 1'b0, 1'b1, 156, 1, act_val);
    checkOutput("coinc_pop_head", act_val, 8'h10);
    busRead(ADDR_STATUS, rd_val);
    checkOutput("coinc_full_no_ovr", rd_val, 8'h03);
    for (int i = 1; i < 9; i++) begin
      busRead(ADDR_DATA, rd_val);
      checkOutput("coinc_fifo_order", rd_val, 8'h10 + 8'(i));
    end
    busRead(ADDR_STATUS, rd_val);
    checkOutput("coinc_drained", rd_val, 8'h00);

    // Flush empties the FIFO and reads back as 0
    applyStimulus(8'h77, 1'b0, 1'b0, 1'b1, -1, 0, act_val);
    busWrite(ADDR_CTRL, 8'h81);
    busRead(ADDR_STATUS, rd_val);
    checkOutput("flush_status", rd_val, 8'h00);
    busRead(ADDR_CTRL, rd_val);
    checkOutput("flush_ctrl", rd_val, 8'h01);

    // 0.4-bit glitch on an idle line: start detected, then rejected
    @(negedge clk);
    rx_serial = 1'b0;
    repeat (4) @(negedge clk);
    #1 checkOutput("glitch_busy", {7'd0, ready}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rx_serial = 1'b1;
    repeat (32) @(negedge clk);
    #1 checkOutput("glitch_ready", {7'd0, ready}, 8'h01);
    busRead(ADDR_STATUS, rd_val);
    checkOutput("glitch_status", rd_val, 8'h00);

    // EN cleared in the middle of data bit 4, then a clean frame
    applyStimulus(8'h33, 1'b0, 1'b0, 1'b1, 88, 2, act_val);
    busRead(ADDR_STATUS, rd_val);
    checkOutput("en_clr_status", rd_val, 8'h00);
    checkOutput("en_clr_ready", {7'd0, ready}, 8'h00);
    busWrite(ADDR_CTRL, 8'h01);
    applyStimulus(8'h5A, 1'b0, 1'b0, 1'b1, -1, 0, act_val);
    busRead(ADDR_DATA, rd_val);
    checkOutput("en_reenable_data", rd_val, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
